// File: rtl/bmf_adder_pkg.sv
// Shared constants and helpers for the BMF-partitioned pipelined approximate adder.
package bmf_adder_pkg;

  localparam int unsigned SLICE_W_DEF = 4;

  // Number of pipeline slices for a given operand width and slice width.
  function automatic int unsigned nslice(input int unsigned width, input int unsigned slice_w);
    return width / slice_w;
  endfunction

  // BMF approximation on the two low sum bits: the LSB is aliased to bit 1.
  function automatic logic [1:0] approx_slice(input logic [1:0] s_lo);
    return {s_lo[1], s_lo[1]};
  endfunction

endpackage

// File: rtl/bmf_slice_add.sv
// One combinational SLICE_W-bit adder slice with optional BMF approximation of the sum LSB.
module bmf_slice_add
  import bmf_adder_pkg::*;
#(
  parameter int unsigned SLICE_W = SLICE_W_DEF
) (
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  input  logic               i_approx,
  output logic [SLICE_W-1:0] o_s,
  output logic               o_cout,
  output logic               o_err
);

  localparam int unsigned SUM_W = SLICE_W + 1;

  logic [SLICE_W:0] w_exact;

  assign w_exact = {1'b0, i_a} + {1'b0, i_b} + SUM_W'(i_cin);

  // Exact slice sum, with the low bit aliased when this slice runs approximate.
  always_comb begin
    o_s = w_exact[SLICE_W-1:0];
    if (i_approx) begin
      o_s[1:0] = approx_slice(w_exact[1:0]);
    end
  end

  // Carry stays exact so the approximation never propagates upward.
  assign o_cout = w_exact[SLICE_W];
  assign o_err  = i_approx & (w_exact[0] ^ w_exact[1]);

endmodule

// File: rtl/bmf_approx_adder_pipe.sv
// Pipelined approximate adder: one slice per stage, carry ripples stage to stage, global stall.
module bmf_approx_adder_pipe
  import bmf_adder_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SLICE_W = SLICE_W_DEF,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned NSLICE = nslice(WIDTH, SLICE_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic              in_cin,
  input  logic [NSLICE-1:0] in_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_sum,
  output logic              out_cout,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_count,
  input  logic              err_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Stage k register set; stage 0 holds the captured operands, stage NSLICE feeds the outputs.
  // r_a holds finished sum slices in its top bits and not-yet-added A slices in its low bits;
  // each stage consumes the low slice and rotates its sum in at the top.
  logic [WIDTH-1:0]  r_a [NSLICE+1];
  logic [WIDTH-1:0]  r_b [NSLICE+1];
  logic [NSLICE-1:0] r_m [NSLICE+1];
  logic              r_c [NSLICE+1];
  logic              r_e [NSLICE+1];
  logic              r_v [NSLICE+1];
  logic [CNT_W-1:0]  r_cnt;

  logic [SLICE_W-1:0] w_s  [NSLICE];
  logic               w_co [NSLICE];
  logic               w_e  [NSLICE];
  logic               w_adv;
  logic               w_out_xfer;

  assign w_adv      = ~r_v[NSLICE] | out_ready;
  assign w_out_xfer = r_v[NSLICE] & out_ready;

  // One slice adder per pipeline stage, always working on the stage's low slice.
  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    bmf_slice_add #(
      .SLICE_W (SLICE_W)
    ) u_slice (
      .i_a      (r_a[k][SLICE_W-1:0]),
      .i_b      (r_b[k][SLICE_W-1:0]),
      .i_cin    (r_c[k]),
      .i_approx (r_m[k][0]),
      .o_s      (w_s[k]),
      .o_cout   (w_co[k]),
      .o_err    (w_e[k])
    );
  end

  // Pipeline registers: capture on acceptance, shift every stage together when advancing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= NSLICE; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_m[k] <= '0;
        r_c[k] <= 1'b0;
        r_e[k] <= 1'b0;
        r_v[k] <= 1'b0;
      end
    end else if (w_adv) begin
      r_v[0] <= in_valid;
      r_a[0] <= in_a;
      r_b[0] <= in_b;
      r_m[0] <= in_mask;
      r_c[0] <= in_cin;
      r_e[0] <= 1'b0;
      for (int k = 0; k < NSLICE; k++) begin
        r_v[k+1] <= r_v[k];
        r_a[k+1] <= (r_a[k] >> SLICE_W) | (WIDTH'(w_s[k]) << (WIDTH - SLICE_W));
        r_b[k+1] <= r_b[k] >> SLICE_W;
        r_m[k+1] <= r_m[k] >> 1;
        r_c[k+1] <= w_co[k];
        r_e[k+1] <= r_e[k] | w_e[k];
      end
    end
  end

  // Saturating count of delivered erroneous results; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (err_clr) begin
      r_cnt <= '0;
    end else if (w_out_xfer && r_e[NSLICE] && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r_v[NSLICE];
  assign out_sum   = r_a[NSLICE];
  assign out_cout  = r_c[NSLICE];
  assign out_err   = r_e[NSLICE];
  assign err_count = r_cnt;

endmodule

// File: tb/tb_bmf_approx_adder_pipe.sv
// Self-checking bench for bmf_approx_adder_pipe (WIDTH=32, SLICE_W=4, CNT_W=4).
module tb_bmf_approx_adder_pipe;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        err;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_cin, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_sum;
  logic [7:0]  in_mask;
  logic        out_cout, out_err, err_clr;
  logic [3:0]  err_count;

  int   nvec = 0;
  int   nfail = 0;
  int   model_cnt = 0;
  int   spurious = 0;
  res_t exp_q[$];
  res_t ref_q[$];
  res_t got_q[$];

  bmf_approx_adder_pipe #(.WIDTH(32), .SLICE_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_mask(in_mask), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_err(out_err), .err_count(err_count),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Reference: exact 33-bit sum, then alias bit 4i to bit 4i+1 for every approximate slice.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                 input logic [7:0] m);
    logic [32:0] ex;
    res_t r;
    ex     = {1'b0, a} + {1'b0, b} + 33'(cin);
    r.sum  = ex[31:0];
    r.cout = ex[32];
    r.err  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        if (ex[4*i] != ex[4*i+1]) r.err = 1'b1;
        r.sum[4*i] = ex[4*i+1];
      end
    end
    return r;
  endfunction

  // Record transfers of the current (settled) cycle, then advance one clock.
  task automatic cycle();
    res_t e;
    e = '0;
    if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin, in_mask));
    if (out_valid && out_ready) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else spurious++;
      ref_q.push_back(e);
      got_q.push_back({out_sum, out_cout, out_err});
    end
    if (err_clr) model_cnt = 0;
    else if (out_valid && out_ready && e.err && model_cnt < 15) model_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    exp_q.delete();
    ref_q.delete();
    got_q.delete();
  endtask

  task automatic drive_random(input logic force_err);
    in_valid = 1'b1;
    in_a     = $urandom();
    in_b     = $urandom();
    in_cin   = 1'($urandom());
    in_mask  = 8'($urandom());
    if (force_err) begin
      in_a    = {in_a[31:4], 4'h1};
      in_b    = {in_b[31:4], 4'h0};
      in_cin  = 1'b0;
      in_mask = 8'h01;
    end
  endtask

  // Stream n random operations with the consumer always ready until n results arrive.
  task automatic run_ops(input int n, input logic force_err, output logic ok);
    int  sent;
    logic acc;
    sent = 0;
    for (int it = 0; it < 400 && got_q.size() < n; it++) begin
      out_ready = 1'b1;
      if (!in_valid && sent < n) drive_random(force_err);
      #1;
      acc = in_valid && in_ready;
      cycle();
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    ok = (got_q.size() == n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_mask = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    nvec++;
    if ({out_valid, out_sum, out_cout, out_err, err_count} !== 39'd0) begin
      nfail++;
      $display("FAIL reset_state: got valid=%b sum=%h cout=%b err=%b cnt=%0d, want all zero",
               out_valid, out_sum, out_cout, out_err, err_count);
    end
    nvec++;
    if (in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    cycle();
  endtask

  task automatic test_single(input string name, input logic do_clr, input logic [31:0] a,
                             input logic [31:0] b, input logic cin, input logic [7:0] m,
                             input logic [31:0] x_sum, input logic x_cout, input logic x_err,
                             input logic [3:0] x_cnt);
    int n;
    clear_queues();
    out_ready = 1'b1;
    if (do_clr) begin
      err_clr = 1'b1;
      #1;
      cycle();
      err_clr = 1'b0;
    end
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_mask = m;
    #1;
    cycle();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      cycle();
      n++;
    end
    nvec++;
    if (n !== 8) begin
      nfail++;
      $display("FAIL %s_latency: got %0d cycles want 8", name, n);
    end
    nvec++;
    if ({out_sum, out_cout, out_err} !== {x_sum, x_cout, x_err}) begin
      nfail++;
      $display("FAIL %s_result: got sum=%h cout=%b err=%b want sum=%h cout=%b err=%b",
               name, out_sum, out_cout, out_err, x_sum, x_cout, x_err);
    end
    cycle();
    nvec++;
    if (err_count !== x_cnt) begin
      nfail++;
      $display("FAIL %s_err_count: got %0d want %0d", name, err_count, x_cnt);
    end
  endtask

  task automatic test_stream_stall();
    int   sent, cyc;
    logic acc, stalled_prev;
    res_t prev;
    clear_queues();
    sent = 0; cyc = 0; stalled_prev = 1'b0; prev = '0;
    in_valid = 1'b0;
    while (got_q.size() < 12 && cyc < 300) begin
      out_ready = !(cyc >= 10 && cyc < 15);
      if (!in_valid && sent < 12) drive_random(1'b0);
      #1;
      if (out_valid && !out_ready) begin
        nvec++;
        if (in_ready !== 1'b0) begin
          nfail++;
          $display("FAIL stall_in_ready: cycle %0d got %b want 0", cyc, in_ready);
        end
        if (stalled_prev) begin
          nvec++;
          if ({out_sum, out_cout, out_err} !== prev) begin
            nfail++;
            $display("FAIL stall_hold: cycle %0d got %h want %h", cyc,
                     {out_sum, out_cout, out_err}, prev);
          end
        end
        prev = {out_sum, out_cout, out_err};
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      acc = in_valid && in_ready;
      cycle();
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
      cyc++;
    end
    out_ready = 1'b1;
    nvec++;
    if (got_q.size() != 12) begin
      nfail++;
      $display("FAIL stream_count: got %0d results want 12", got_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      nvec++;
      if (got_q[i] !== ref_q[i]) begin
        nfail++;
        $display("FAIL stream_item%0d: got %h want %h", i, got_q[i], ref_q[i]);
      end
    end
  endtask

  task automatic test_saturate_clear();
    logic ok;
    int   n;
    clear_queues();
    out_ready = 1'b1;
    err_clr = 1'b1;
    #1;
    cycle();
    err_clr = 1'b0;
    run_ops(20, 1'b1, ok);
    nvec++;
    if (!ok || err_count !== 4'd15 || model_cnt != 15) begin
      nfail++;
      $display("FAIL saturate: got cnt=%0d (results ok=%b) want 15", err_count, ok);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      nvec++;
      if (got_q[i] !== ref_q[i]) begin
        nfail++;
        $display("FAIL saturate_item%0d: got %h want %h", i, got_q[i], ref_q[i]);
      end
    end
    // Clear coinciding with an erroring output, first from saturation then from a count of 1.
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        clear_queues();
        run_ops(1, 1'b1, ok);
        nvec++;
        if (err_count !== 4'd1) begin
          nfail++;
          $display("FAIL count_after_clear: got %0d want 1", err_count);
        end
      end
      clear_queues();
      drive_random(1'b1);
      #1;
      cycle();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
        cycle();
        n++;
      end
      err_clr = 1'b1;
      #1;
      nvec++;
      if (out_err !== 1'b1) begin
        nfail++;
        $display("FAIL clr_setup%0d: out_err got %b want 1", pass, out_err);
      end
      cycle();
      err_clr = 1'b0;
      nvec++;
      if (err_count !== 4'd0) begin
        nfail++;
        $display("FAIL clr_priority%0d: got %0d want 0", pass, err_count);
      end
    end
  endtask

  task automatic test_reset_flush();
    logic ok;
    int   seen;
    clear_queues();
    run_ops(1, 1'b1, ok);
    nvec++;
    if (!ok || err_count !== 4'd1) begin
      nfail++;
      $display("FAIL flush_setup: got cnt=%0d ok=%b want cnt=1", err_count, ok);
    end
    for (int i = 0; i < 5; i++) begin
      drive_random(1'b1);
      #1;
      cycle();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || err_count !== 4'd0 || in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL flush_immediate: got valid=%b cnt=%0d in_ready=%b want 0/0/1",
               out_valid, err_count, in_ready);
    end
    exp_q.delete();
    model_cnt = 0;
    spurious  = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_queues();
    seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (out_valid) seen++;
      cycle();
    end
    nvec++;
    if (seen != 0 || spurious != 0) begin
      nfail++;
      $display("FAIL flush_stale: got %0d stale outputs want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_single("add_exact", 1'b1, 32'h1, 32'h1, 1'b0, 8'h00, 32'h2, 1'b0, 1'b0, 4'd0);
    test_single("lsb_alias", 1'b1, 32'h1, 32'h0, 1'b0, 8'h01, 32'h0, 1'b0, 1'b1, 4'd1);
    test_single("ripple_all", 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, 8'hFF, 32'h0, 1'b1, 1'b0, 4'd1);
    test_stream_stall();
    test_saturate_clear();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

endmodule
